host_obi_burst_master: RTL

- OBI initiator used by the host-side testbench and host glue to move bursts of 32-bit words to and from any OBI responder, for example the host memory model.
- Accepts one burst command at a time: base address, word count, direction and byte enables.
- Issues one OBI transaction per word, with strictly one transaction outstanding.
- Read data streams out on a valid/ready port; write data streams in on a valid/ready port.

---
 rtl/host_obi_burst_master_if.sv | 21 ++
 rtl/host_obi_burst_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/host_obi_burst_master_if.sv
// OBI request/grant and response channel bundles shared by the host burst master
// and any OBI responder it talks to.
interface obi_req_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;

    modport master (output req, output we, output be, output addr, output wdata, input gnt);
    modport slave  (input req, input we, input be, input addr, input wdata, output gnt);
endinterface

interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output rvalid, output rdata);
    modport slave  (input rvalid, input rdata);
endinterface

// File: rtl/host_obi_burst_master.sv
// OBI burst initiator: one command at a time, one word per OBI transaction,
// strictly one transaction outstanding, valid/ready streams for read and write data.
module host_obi_burst_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [3:0]       cmd_be_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [31:0]      wdata_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [31:0]      rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    obi_req_if.master        host_mem_req,
    obi_rsp_if.slave         host_mem_rsp
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_REQ   = 3'd2,
        ST_RSP   = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [31:0]      addr_r, addr_s;
    logic [31:0]      wdata_r, wdata_s;
    logic [31:0]      rdata_r, rdata_s;
    logic             we_r, we_s;
    logic [3:0]       be_r, be_s;
    logic [LEN_W-1:0] rem_r, rem_s;
    logic             err_r, err_s, err_set_s;
    logic             cmd_ready_r, wdata_ready_r, req_r, rdata_valid_r, busy_r, done_r;
    logic             unused_s;

    // Low address bits are dropped: every transfer is word aligned.
    assign unused_s  = ^cmd_addr_i[1:0];
    assign err_set_s = host_mem_rsp.rvalid && (state_r != ST_RSP);

    // Next-state and datapath-register update for the burst sequencer.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        we_s    = we_r;
        be_s    = be_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        rem_s   = rem_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_s = {cmd_addr_i[31:2], 2'b00};
                    we_s   = cmd_we_i;
                    be_s   = cmd_be_i;
                    rem_s  = cmd_len_i;
                    err_s  = 1'b0;
                    if (cmd_len_i == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else if (cmd_we_i) begin
                        state_s = ST_WDATA;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (wdata_valid_i) begin
                    wdata_s = wdata_i;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_REQ: begin
                if (host_mem_req.gnt) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (!host_mem_rsp.rvalid) begin
                    state_s = ST_RSP;
                end else if (!we_r) begin
                    rdata_s = host_mem_rsp.rdata;
                    state_s = ST_OUT;
                end else if (rem_r == LEN_ONE) begin
                    rem_s   = rem_r - LEN_ONE;
                    state_s = ST_DONE;
                end else begin
                    rem_s   = rem_r - LEN_ONE;
                    addr_s  = addr_r + 32'd4;
                    state_s = ST_WDATA;
                end
            end
            ST_OUT: begin
                if (!rdata_ready_i) begin
                    state_s = ST_OUT;
                end else if (rem_r == LEN_ONE) begin
                    rem_s   = rem_r - LEN_ONE;
                    state_s = ST_DONE;
                end else begin
                    rem_s   = rem_r - LEN_ONE;
                    addr_s  = addr_r + 32'd4;
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and decoded-output registers; outputs are flopped from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'h0000_0000;
            wdata_r       <= 32'h0000_0000;
            rdata_r       <= 32'h0000_0000;
            we_r          <= 1'b0;
            be_r          <= 4'h0;
            rem_r         <= LEN_ZERO;
            err_r         <= 1'b0;
            cmd_ready_r   <= 1'b1;
            wdata_ready_r <= 1'b0;
            req_r         <= 1'b0;
            rdata_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            rdata_r       <= rdata_s;
            we_r          <= we_s;
            be_r          <= be_s;
            rem_r         <= rem_s;
            // A stray response outranks the clear on command accept.
            err_r         <= err_s | err_set_s;
            cmd_ready_r   <= (state_s == ST_IDLE);
            wdata_ready_r <= (state_s == ST_WDATA);
            req_r         <= (state_s == ST_REQ);
            rdata_valid_r <= (state_s == ST_OUT);
            busy_r        <= (state_s != ST_IDLE);
            done_r        <= (state_s == ST_DONE);
        end
    end

    assign cmd_ready_o        = cmd_ready_r;
    assign wdata_ready_o      = wdata_ready_r;
    assign rdata_valid_o      = rdata_valid_r;
    assign rdata_o            = rdata_r;
    assign busy_o             = busy_r;
    assign done_o             = done_r;
    assign err_o              = err_r;
    assign host_mem_req.req   = req_r;
    assign host_mem_req.we    = we_r;
    assign host_mem_req.be    = be_r;
    assign host_mem_req.addr  = addr_r;
    assign host_mem_req.wdata = wdata_r;

endmodule
